mem_wb_dcache: RTL and testbench
================================

Name: mem_wb_dcache

Overview:
- Parametrised write-back, write-allocate, direct-mapped data cache with multi-word lines, sitting between the MEM stage and mem_ctrl.
- Serves LB/LH/LW/LBU/LHU/SB/SH/SW requests.
- Store hits complete without memory traffic (dirty bit).
- Misses evict the dirty victim word-by-word, then refill the line before completing; MEM stalls on req_ready.

Parameters:
- ADDR_W, 32, byte-address width.
- LINES, 64, number of lines; power of 2, >=2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, >=1.
- Derived: OFF_W=log2(LINE_WORDS), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W-2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_ready  out  1  cache in IDLE, able to accept.
- resp_valid  out  1  one-cycle completion pulse (loads and stores).
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_misaligned  out  1  one-cycle pulse: request rejected as misaligned.
- mc_if_busy  in  1  mem_ctrl serving instruction fetch.
- mc_req  out  1  word transfer request.
- mc_we  out  1  1=write.
- mc_addr  out  ADDR_W  word-aligned address.
- mc_wdata  out  32  write word.
- mc_done  in  1  one-cycle transfer-complete pulse.
- mc_rdata  in  32  read word, valid with mc_done.

Behaviour:
- Reset (rst low, async): all valid/dirty cleared, FSM=IDLE. Outputs: req_ready=1; resp_valid, resp_misaligned, mc_req, mc_we=0; resp_rdata, mc_addr, mc_wdata=0. Data/tag arrays not reset.
- Address split: [1:0] byte, [OFF_W+1:2] word, next IDX_W bits index, top TAG_W bits tag.
- FSM states: IDLE, WBACK, REFILL, DONE.
- IDLE, req_valid:
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): resp_misaligned=1 next cycle. No state change, no memory access.
  - Hit (valid && tag match): completed in the accept cycle. resp_valid=1 next cycle (latency 1), req_ready stays 1, back-to-back hits each cycle.
  - Store hit: only the addressed byte lanes are merged (SB 1 lane, SH 2 lanes, SW 4 lanes); dirty set.
  - Miss: request latched, req_ready=0. Go to WBACK if victim valid&&dirty, else REFILL.
- WBACK: writes LINE_WORDS words, word 0 upward, to {victim_tag,idx,w,2'b00}. Then REFILL, dirty cleared.
- REFILL: reads LINE_WORDS words, word 0 upward, from {req_tag,idx,w,2'b00} into the line. After the last word: tag written, valid=1, dirty=0, go to DONE.
- DONE: performs the latched access on the now-resident line exactly as a hit. Store sets dirty. resp_valid=1 next cycle, return to IDLE, req_ready=1 in that same cycle.
- mc handshake:
  - mc_req may rise only in a cycle where mc_if_busy=0.
  - Once raised, mc_req, mc_we, mc_addr and mc_wdata are held stable until mc_done, regardless of mc_if_busy.
  - mc_req drops in the cycle after mc_done. The next word's request may rise in the cycle after that (one idle cycle between words).
  - mc_done while mc_req=0 is ignored.
- Miss latency, clean victim: mc-bound. Minimum = LINE_WORDS x (1 + mc latency + 1) + 2 cycles.
- Load extension:
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- req_valid while req_ready=0 is ignored; MEM holds the request until resp_valid.
- Reset mid-miss: FSM returns to IDLE immediately; mc_req drops asynchronously. The partially refilled line stays invalid. Any in-flight mc transfer is abandoned; mem_ctrl is reset by the same rst.
- Line flush and coherence with instruction fetch are not provided; self-modifying code is unsupported.

Test Plan:
- Reset, then LW 0x0000_1000 (cold) -> 4 mc reads at 0x1000/04/08/0C, in order; resp_rdata = mc word for 0x1000; req_ready low throughout until DONE+1.
- LW 0x1004 immediately after -> hit, resp_valid exactly 1 cycle after accept, no mc_req.
- Word 0x1000 = 0x1234_5678; SB 0x1001 data 0xFF, then LB 0x1001 -> 0xFFFF_FFFF; LBU 0x1001 -> 0x0000_00FF; LW 0x1000 -> 0x1234_FF78; no mc writes.
- With defaults, LW 0x2000 (same index, dirty victim) -> 4 mc writes to 0x1000..0x100C (word0=0x1234_FF78), then 4 reads at 0x2000..0x200C; subsequent LW 0x1000 misses and refills 0x1234_FF78.
- Miss with mc_if_busy=1 for 5 cycles -> mc_req stays 0; rises the cycle mc_if_busy falls. Toggling mc_if_busy after mc_req rises -> mc_req/mc_addr unchanged until mc_done.
- LH 0x1003 -> resp_misaligned pulse, no resp_valid, no mc_req. Assert rst low during REFILL word 2 -> mc_req=0 immediately, req_ready=1; re-access of that line misses.

Source files
------------

// File: rtl/mem_wb_dcache.sv
// Write-back, write-allocate, direct-mapped data cache between the MEM stage and mem_ctrl.
// Misses write back a dirty victim line word by word, then refill it before completing.
module mem_wb_dcache #(
  parameter int ADDR_W     = 32,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  input  logic              mc_if_busy,
  output logic              mc_req,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [31:0]       mc_wdata,
  input  logic              mc_done,
  input  logic [31:0]       mc_rdata
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam int WI_W  = (OFF_W > 0) ? OFF_W : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WBACK  = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> (OFF_W + 2));
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (OFF_W + 2 + IDX_W));
  endfunction

  function automatic logic [WI_W-1:0] f_word(input logic [ADDR_W-1:0] a);
    return WI_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
  endfunction

  function automatic logic [ADDR_W-1:0] f_line_addr(input logic [TAG_W-1:0] t,
                                                    input logic [IDX_W-1:0] i,
                                                    input logic [WI_W-1:0]  w);
    return (ADDR_W'(t) << (OFF_W + 2 + IDX_W)) | (ADDR_W'(i) << (OFF_W + 2)) | (ADDR_W'(w) << 2);
  endfunction

  logic [31:0]      data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q, dirty_q;

  logic [1:0]        state;
  logic              lat_we, lat_uns;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [WI_W-1:0]   wcnt;

  logic              req_mis, req_hit, hit_go, miss_go, acc_en, acc_we, acc_uns, last_word;
  logic [IDX_W-1:0]  req_idx, lat_idx, acc_idx;
  logic [TAG_W-1:0]  req_tag, lat_tag;
  logic [WI_W-1:0]   acc_word;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_size;
  logic [31:0]       acc_wdata, old_word, st_lanes, st_word, ld_data;
  logic [3:0]        be;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;

  assign req_ready = (state == S_IDLE);

  // Hits and the post-refill DONE cycle share one access path, fed from the live or latched request.
  always_comb begin
    req_idx  = f_idx(req_addr);
    req_tag  = f_tag(req_addr);
    lat_idx  = f_idx(lat_addr);
    lat_tag  = f_tag(lat_addr);
    req_mis  = req_valid && ((req_size == 2'b01 && req_addr[0]) ||
                             (req_size[1] && req_addr[1:0] != 2'b00));
    req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    hit_go   = (state == S_IDLE) && req_valid && !req_mis && req_hit;
    miss_go  = (state == S_IDLE) && req_valid && !req_mis && !req_hit;
    acc_en   = hit_go || (state == S_DONE);

    acc_addr  = (state == S_DONE) ? lat_addr  : req_addr;
    acc_we    = (state == S_DONE) ? lat_we    : req_we;
    acc_size  = (state == S_DONE) ? lat_size  : req_size;
    acc_uns   = (state == S_DONE) ? lat_uns   : req_unsigned;
    acc_wdata = (state == S_DONE) ? lat_wdata : req_wdata;
    acc_idx   = f_idx(acc_addr);
    acc_word  = f_word(acc_addr);
    old_word  = data_q[acc_idx][acc_word];

    case (acc_size)
      2'b00: begin
        be       = 4'b0001 << acc_addr[1:0];
        st_lanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        st_lanes = acc_wdata;
      end
    endcase
    for (int unsigned i = 0; i < 4; i++)
      st_word[i*8 +: 8] = be[i] ? st_lanes[i*8 +: 8] : old_word[i*8 +: 8];

    ld_b = old_word[{acc_addr[1:0], 3'b000} +: 8];
    ld_h = acc_addr[1] ? old_word[31:16] : old_word[15:0];
    case (acc_size)
      2'b00:   ld_data = {{24{~acc_uns & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{~acc_uns & ld_h[15]}}, ld_h};
      default: ld_data = old_word;
    endcase

    last_word = (wcnt == WI_W'(LINE_WORDS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      wcnt            <= '0;
      lat_we          <= 1'b0;
      lat_uns         <= 1'b0;
      lat_size        <= '0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      mc_req          <= 1'b0;
      mc_we           <= 1'b0;
      mc_addr         <= '0;
      mc_wdata        <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
    end else begin
      resp_valid      <= acc_en;
      resp_misaligned <= (state == S_IDLE) && req_mis;
      if (acc_en) begin
        resp_rdata <= acc_we ? '0 : ld_data;
        if (acc_we) dirty_q[acc_idx] <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (miss_go) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            wcnt      <= '0;
            state     <= (valid_q[req_idx] && dirty_q[req_idx]) ? S_WBACK : S_REFILL;
          end
        end
        S_WBACK, S_REFILL: begin
          if (mc_req) begin
            if (mc_done) begin
              mc_req <= 1'b0;
              wcnt   <= wcnt + 1'b1;
              if (last_word) begin
                wcnt <= '0;
                dirty_q[lat_idx] <= 1'b0;
                if (state == S_WBACK) begin
                  state <= S_REFILL;
                end else begin
                  valid_q[lat_idx] <= 1'b1;
                  state            <= S_DONE;
                end
              end
            end
          end else if (!mc_if_busy) begin
            mc_req   <= 1'b1;
            mc_we    <= (state == S_WBACK);
            mc_addr  <= f_line_addr((state == S_WBACK) ? tag_q[lat_idx] : lat_tag, lat_idx, wcnt);
            mc_wdata <= (state == S_WBACK) ? data_q[lat_idx][wcnt] : '0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we) data_q[acc_idx][acc_word] <= st_word;
    if (state == S_REFILL && mc_req && mc_done) begin
      data_q[lat_idx][wcnt] <= mc_rdata;
      if (last_word) tag_q[lat_idx] <= lat_tag;
    end
  end

endmodule

// File: tb/tb_mem_wb_dcache.sv
// Directed bench for mem_wb_dcache with a fixed-latency mem_ctrl model and transfer log.
module tb_mem_wb_dcache;
  localparam int MC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic        mc_if_busy = 1'b0;
  logic        mc_req, mc_we;
  logic [31:0] mc_addr, mc_wdata;
  logic        mc_done = 1'b0;
  logic [31:0] mc_rdata = '0;

  mem_wb_dcache #(.ADDR_W(32), .LINES(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mc_if_busy(mc_if_busy), .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int proto_err = 0;
  logic [31:0] mem [logic [31:0]];
  logic        log_we [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5555_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mem_ctrl model: answers MC_LAT cycles after mc_req rises; flags handshake violations.
  logic        prev_req = 1'b0;
  int          mc_cnt = 0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      mc_done  = 1'b0;
      mc_cnt   = 0;
      prev_req = 1'b0;
    end else begin
      if (mc_done) begin
        mc_done = 1'b0;
        if (mc_req) proto_err++;
      end else if (mc_req) begin
        if (!prev_req) begin
          if (mc_if_busy) proto_err++;
          h_we = mc_we; h_addr = mc_addr; h_wdata = mc_wdata;
          mc_cnt = 0;
        end else if (mc_we !== h_we || mc_addr !== h_addr || mc_wdata !== h_wdata) begin
          proto_err++;
        end
        mc_cnt++;
        if (mc_cnt == MC_LAT) begin
          mc_done = 1'b1;
          log_we.push_back(mc_we);
          log_addr.push_back(mc_addr);
          log_data.push_back(mc_wdata);
          if (mc_we) mem[mc_addr] = mc_wdata;
          else mc_rdata = rd_mem(mc_addr);
        end
      end
      prev_req = mc_req;
    end
  end

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
  endtask

  // Called just after a negedge; returns just after the negedge of the response cycle.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic mis,
                        output logic vld, output logic rerr, output logic smc);
    drive(we, sz, uns, a, wd);
    lat = 0; rerr = 1'b0; smc = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (mc_req) smc = 1'b1;
      if (resp_valid || resp_misaligned) break;
      if (req_ready) rerr = 1'b1;
    end
    check("resp_seen", {31'b0, resp_valid | resp_misaligned}, 32'd1);
    rd = resp_rdata; mis = resp_misaligned; vld = resp_valid;
    req_valid = 1'b0;
  endtask

  task automatic hit_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    logic        mis, vld, rerr, smc;
    do_req(we, sz, uns, a, wd, rd, lat, mis, vld, rerr, smc);
    check({tag, "_data"}, rd, exp);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_nomc"}, {31'b0, smc}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat, base;
    logic        mis, vld, rerr, smc;
    logic [31:0] exp_a [8];
    logic [31:0] exp_d [4];

    mem[32'h1000] = 32'h1234_5678; mem[32'h1004] = 32'h89AB_CDEF;
    mem[32'h1008] = 32'h0BAD_F00D; mem[32'h100C] = 32'h1357_9BDF;
    mem[32'h2000] = 32'hA5A5_A5A5; mem[32'h2004] = 32'h5A5A_5A5A;
    mem[32'h2008] = 32'hDEAD_BEEF; mem[32'h200C] = 32'hFEED_FACE;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_misaligned", {31'b0, resp_misaligned}, 32'd0);
    check("rst_mc_req", {31'b0, mc_req}, 32'd0);
    check("rst_mc_we", {31'b0, mc_we}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    check("rst_mc_wdata", mc_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss
    base = log_addr.size();
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, lat, mis, vld, rerr, smc);
    check("cold_data", rd, 32'h1234_5678);
    check("cold_ready_low", {31'b0, rerr}, 32'd0);
    check("cold_ready_back", {31'b0, req_ready}, 32'd1);
    check("cold_nxfer", 32'(log_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("cold_addr", log_addr[base + i], 32'h1000 + 32'(4 * i));
      check("cold_we", {31'b0, log_we[base + i]}, 32'd0);
    end

    // Hits, byte-lane stores and load extension
    hit_op("lw_1004", 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'h89AB_CDEF);
    hit_op("sb_1001", 1'b1, 2'b00, 1'b0, 32'h1001, 32'h0000_00FF, 32'h0);
    hit_op("lb_1001", 1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 32'hFFFF_FFFF);
    hit_op("lbu_1001", 1'b0, 2'b00, 1'b1, 32'h1001, 32'h0, 32'h0000_00FF);
    hit_op("lw_1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h1234_FF78);
    hit_op("lh_1000", 1'b0, 2'b01, 1'b0, 32'h1000, 32'h0, 32'hFFFF_FF78);
    hit_op("lhu_1000", 1'b0, 2'b01, 1'b1, 32'h1000, 32'h0, 32'h0000_FF78);
    hit_op("lh_1002", 1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 32'h0000_1234);
    hit_op("sh_100a", 1'b1, 2'b01, 1'b0, 32'h100A, 32'hDEAD_8001, 32'h0);
    hit_op("lh_100a", 1'b0, 2'b01, 1'b0, 32'h100A, 32'h0, 32'hFFFF_8001);
    hit_op("lbu_100b", 1'b0, 2'b00, 1'b1, 32'h100B, 32'h0, 32'h0000_0080);
    hit_op("lw_1008", 1'b0, 2'b10, 1'b0, 32'h1008, 32'h0, 32'h8001_F00D);
    hit_op("sw_100c", 1'b1, 2'b10, 1'b0, 32'h100C, 32'h1122_3344, 32'h0);
    hit_op("lw_100c", 1'b0, 2'b10, 1'b0, 32'h100C, 32'h0, 32'h1122_3344);

    // Dirty victim: write back 0x1000 line, then refill 0x2000 line
    base = log_addr.size();
    do_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, rd, lat, mis, vld, rerr, smc);
    exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h2000, 32'h2004, 32'h2008, 32'h200C};
    exp_d = '{32'h1234_FF78, 32'h89AB_CDEF, 32'h8001_F00D, 32'h1122_3344};
    check("wb_data", rd, 32'hA5A5_A5A5);
    check("wb_ready_low", {31'b0, rerr}, 32'd0);
    check("wb_nxfer", 32'(log_addr.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("wb_addr", log_addr[base + i], exp_a[i]);
      check("wb_we", {31'b0, log_we[base + i]}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) check("wb_wdata", log_data[base + i], exp_d[i]);
    end

    // Re-fetch of the written-back line
    base = log_addr.size();
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, lat, mis, vld, rerr, smc);
    check("refetch_data", rd, 32'h1234_FF78);
    check("refetch_nxfer", 32'(log_addr.size() - base), 32'd4);
    check("refetch_we", {31'b0, log_we[base]}, 32'd0);

    // mc_if_busy gating and hold-while-busy
    base = log_addr.size();
    mc_if_busy = 1'b1;
    drive(1'b0, 2'b10, 1'b0, 32'h3008, 32'h0);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_no_req", {31'b0, mc_req}, 32'd0);
    end
    mc_if_busy = 1'b0;
    @(negedge clk);
    check("busy_rise_req", {31'b0, mc_req}, 32'd1);
    check("busy_rise_addr", mc_addr, 32'h3000);
    mc_if_busy = 1'b1;
    @(negedge clk);
    check("busy_hold_req", {31'b0, mc_req}, 32'd1);
    check("busy_hold_addr", mc_addr, 32'h3000);
    mc_if_busy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    check("busy_resp", {31'b0, resp_valid}, 32'd1);
    check("busy_data", resp_rdata, 32'h5555_3008);
    check("busy_nxfer", 32'(log_addr.size() - base), 32'd4);
    req_valid = 1'b0;

    // Misaligned requests are rejected without traffic
    base = log_addr.size();
    do_req(1'b0, 2'b01, 1'b0, 32'h1003, 32'h0, rd, lat, mis, vld, rerr, smc);
    check("mis_lh_pulse", {31'b0, mis}, 32'd1);
    check("mis_lh_novalid", {31'b0, vld}, 32'd0);
    check("mis_lh_lat", 32'(lat), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, rd, lat, mis, vld, rerr, smc);
    check("mis_lw_pulse", {31'b0, mis}, 32'd1);
    check("mis_lw_novalid", {31'b0, vld}, 32'd0);
    check("mis_nxfer", 32'(log_addr.size() - base), 32'd0);
    hit_op("lw_300c", 1'b0, 2'b10, 1'b0, 32'h300C, 32'h0, 32'h5555_300C);

    // Reset during refill word 2
    base = log_addr.size();
    drive(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
    @(posedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mc_req && mc_addr == 32'h4008) break;
    end
    check("rstmid_w2_addr", mc_addr, 32'h4008);
    check("rstmid_nxfer", 32'(log_addr.size() - base), 32'd2);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rstmid_mc_req", {31'b0, mc_req}, 32'd0);
    check("rstmid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = log_addr.size();
    do_req(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, rd, lat, mis, vld, rerr, smc);
    check("rstmid_remiss_nxfer", 32'(log_addr.size() - base), 32'd4);
    check("rstmid_remiss_addr", log_addr[base], 32'h4000);
    check("rstmid_remiss_data", rd, 32'h5555_4000);

    check("mc_protocol", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
